// File: rtl/window_gen_3x3_if.sv
// Handshake and window bus between a pixel source/sink and window_gen_3x3.
// The master side feeds column-major pixels and consumes 3x3 windows.
interface window_gen_3x3_if;
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         pix_in;
   logic               win_valid;
   logic signed [31:0] pixel;
   logic [7:0]         data_out_0;
   logic [7:0]         data_out_1;
   logic [7:0]         data_out_2;
   logic [7:0]         data_out_3;
   logic [7:0]         data_out_4;
   logic [7:0]         data_out_5;
   logic [7:0]         data_out_6;
   logic [7:0]         data_out_7;
   logic [7:0]         data_out_8;
   logic               done;

   modport master (
      output start, in_valid, pix_in,
      input  in_ready, win_valid, pixel, done,
      input  data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
      input  data_out_5, data_out_6, data_out_7, data_out_8
   );

   modport slave (
      input  start, in_valid, pix_in,
      output in_ready, win_valid, pixel, done,
      output data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
      output data_out_5, data_out_6, data_out_7, data_out_8
   );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a column-major pixel stream, using a
// 2*row+3 deep delay chain with border masking and a zero-fill flush.
module window_gen_3x3 #(
   parameter int row = 430,
   parameter int col = 554
) (
   input logic              clk,
   input logic              rst,
   window_gen_3x3_if.slave  bus
);
   localparam int          depth_c  = 2 * row + 3;
   localparam logic [31:0] total_c  = 32'(row * col);
   localparam logic [31:0] fill_c   = 32'(row + 2);
   localparam logic [31:0] flush_c  = 32'(row + 1);
   localparam logic [31:0] last_r_c = 32'(row - 1);
   localparam logic [31:0] last_c_c = 32'(col - 1);

   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_run   = 2'd1;
   localparam logic [1:0] st_flush = 2'd2;
   localparam logic [1:0] st_done  = 2'd3;

   logic [1:0]  state_r;
   logic [7:0]  chain_r [depth_c];
   logic [31:0] in_cnt_r;
   logic [31:0] sh_cnt_r;
   logic [31:0] flush_cnt_r;
   logic [31:0] out_r_r;
   logic [31:0] out_c_r;
   logic [31:0] out_p_r;
   logic [31:0] pixel_r;
   logic        shift_r;
   logic        in_ready_r;
   logic        win_valid_r;
   logic        done_r;
   logic [7:0]  dout_r [9];

   logic        accept_s;
   logic        flush_shift_s;
   logic        shift_s;
   logic        emit_s;
   logic        start_ok_s;
   logic [7:0]  shift_in_s;
   logic        top_s, bot_s, left_s, right_s;
   logic [7:0]  win_s [9];

   // Shift qualification and window emit decision for this cycle.
   always_comb begin
      accept_s      = (state_r == st_run) && bus.in_valid && in_ready_r;
      flush_shift_s = (state_r == st_flush) && (flush_cnt_r < flush_c);
      shift_s       = accept_s || flush_shift_s;
      shift_in_s    = accept_s ? bus.pix_in : 8'd0;
      // A window exists once the sample row+1 positions after its center is in the chain.
      emit_s        = shift_r && (sh_cnt_r >= fill_c);
      start_ok_s    = bus.start && ((state_r == st_idle) || (state_r == st_done));
   end

   // Tap selection with out-of-image neighbours forced to zero.
   always_comb begin
      top_s    = (out_r_r == 32'd0);
      bot_s    = (out_r_r == last_r_c);
      left_s   = (out_c_r == 32'd0);
      right_s  = (out_c_r == last_c_c);
      win_s[0] = (top_s || left_s)  ? 8'd0 : chain_r[2*row+2];
      win_s[1] = top_s              ? 8'd0 : chain_r[row+2];
      win_s[2] = (top_s || right_s) ? 8'd0 : chain_r[2];
      win_s[3] = left_s             ? 8'd0 : chain_r[2*row+1];
      win_s[4] = chain_r[row+1];
      win_s[5] = right_s            ? 8'd0 : chain_r[1];
      win_s[6] = (bot_s || left_s)  ? 8'd0 : chain_r[2*row];
      win_s[7] = bot_s              ? 8'd0 : chain_r[row];
      win_s[8] = (bot_s || right_s) ? 8'd0 : chain_r[0];
   end

   // Sample delay chain; stale contents are never exposed, so no reset.
   always_ff @(posedge clk) begin
      if (shift_s) begin
         chain_r[0] <= shift_in_s;
         for (int i = 1; i < depth_c; i++) begin
            chain_r[i] <= chain_r[i-1];
         end
      end
   end

   // Frame control, counters and registered window outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= st_idle;
         in_cnt_r    <= 32'd0;
         sh_cnt_r    <= 32'd0;
         flush_cnt_r <= 32'd0;
         out_r_r     <= 32'd0;
         out_c_r     <= 32'd0;
         out_p_r     <= 32'd0;
         pixel_r     <= 32'd0;
         shift_r     <= 1'b0;
         in_ready_r  <= 1'b0;
         win_valid_r <= 1'b0;
         done_r      <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            dout_r[i] <= 8'd0;
         end
      end else begin
         shift_r     <= shift_s;
         win_valid_r <= emit_s;
         if (shift_s) begin
            sh_cnt_r <= sh_cnt_r + 32'd1;
         end
         if (emit_s) begin
            for (int i = 0; i < 9; i++) begin
               dout_r[i] <= win_s[i];
            end
            pixel_r <= out_p_r;
            out_p_r <= out_p_r + 32'd1;
            if (out_r_r == last_r_c) begin
               out_r_r <= 32'd0;
               out_c_r <= out_c_r + 32'd1;
            end else begin
               out_r_r <= out_r_r + 32'd1;
            end
         end
         case (state_r)
            st_idle: begin
               in_ready_r <= 1'b0;
            end
            st_run: begin
               if (accept_s) begin
                  in_cnt_r <= in_cnt_r + 32'd1;
                  if (in_cnt_r + 32'd1 == total_c) begin
                     state_r    <= st_flush;
                     in_ready_r <= 1'b0;
                  end
               end
            end
            st_flush: begin
               if (flush_shift_s) begin
                  flush_cnt_r <= flush_cnt_r + 32'd1;
               end
               if (win_valid_r && (pixel_r == total_c - 32'd1)) begin
                  state_r <= st_done;
                  done_r  <= 1'b1;
               end
            end
            st_done: begin
               in_ready_r <= 1'b0;
            end
            default: begin
               state_r <= st_idle;
            end
         endcase
         if (start_ok_s) begin
            state_r     <= st_run;
            in_ready_r  <= 1'b1;
            done_r      <= 1'b0;
            in_cnt_r    <= 32'd0;
            sh_cnt_r    <= 32'd0;
            flush_cnt_r <= 32'd0;
            out_r_r     <= 32'd0;
            out_c_r     <= 32'd0;
            out_p_r     <= 32'd0;
            shift_r     <= 1'b0;
            win_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.win_valid  = win_valid_r;
   assign bus.pixel      = pixel_r;
   assign bus.done       = done_r;
   assign bus.data_out_0 = dout_r[0];
   assign bus.data_out_1 = dout_r[1];
   assign bus.data_out_2 = dout_r[2];
   assign bus.data_out_3 = dout_r[3];
   assign bus.data_out_4 = dout_r[4];
   assign bus.data_out_5 = dout_r[5];
   assign bus.data_out_6 = dout_r[6];
   assign bus.data_out_7 = dout_r[7];
   assign bus.data_out_8 = dout_r[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x3 image with pix_in = index+1; windows are
// checked every valid cycle against an arithmetic image model.
module tb_window_gen_3x3;
   localparam int row   = 4;
   localparam int col   = 3;
   localparam int total = row * col;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   window_gen_3x3_if bus();
   window_gen_3x3 #(.row(row), .col(col)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_p = 0;
   int win_count = 0;
   int acc5_cyc = 0;
   int last_cyc = 0;
   int lit0 [9]  = '{0, 0, 0, 0, 1, 5, 0, 2, 6};
   int lit5 [9]  = '{1, 5, 9, 2, 6, 10, 3, 7, 11};
   int lit11 [9] = '{7, 11, 0, 8, 12, 0, 0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (p=%0d, t=%0t)", name, act, exp, exp_p, $time);
      end
   endtask

   // Image value at (rr,cc) as seen by a window: zero outside the image.
   function automatic int model_px(input int p, input int k, input int j);
      int rr = (p % row) + k - 1;
      int cc = (p / row) + j - 1;
      if (rr < 0 || rr >= row || cc < 0 || cc >= col) return 0;
      return cc * row + rr + 1;
   endfunction

   function automatic int dout(input int i);
      case (i)
         0: return int'(bus.data_out_0);
         1: return int'(bus.data_out_1);
         2: return int'(bus.data_out_2);
         3: return int'(bus.data_out_3);
         4: return int'(bus.data_out_4);
         5: return int'(bus.data_out_5);
         6: return int'(bus.data_out_6);
         7: return int'(bus.data_out_7);
         8: return int'(bus.data_out_8);
         default: return -1;
      endcase
   endfunction

   // Every presented window is compared to the model and in-order center index.
   always @(negedge clk) begin
      if (bus.win_valid) begin
         check("pixel", int'(bus.pixel), exp_p);
         for (int i = 0; i < 9; i++) check("window", dout(i), model_px(exp_p, i / 3, i % 3));
         if (exp_p == 0) begin
            check("first_latency", cyc - acc5_cyc, 1);
            for (int i = 0; i < 9; i++) check("lit_p0", dout(i), lit0[i]);
         end
         if (exp_p == 5) for (int i = 0; i < 9; i++) check("lit_p5", dout(i), lit5[i]);
         if (exp_p == total - 1) begin
            for (int i = 0; i < 9; i++) check("lit_p11", dout(i), lit11[i]);
            last_cyc = cyc;
         end
         exp_p++;
         win_count++;
      end
   end

   task automatic new_frame;
      exp_p = 0;
      win_count = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ready_after_start", int'(bus.in_ready), 1);
      check("done_after_start", int'(bus.done), 0);
   endtask

   task automatic feed(input logic [15:0] pat, input int stop_at, input int start_at);
      int idx = 0;
      int guard = 0;
      logic acc;
      while (idx < stop_at && guard < 500) begin
         bus.in_valid = pat[guard % 16];
         bus.pix_in   = 8'(idx + 1);
         bus.start    = (idx == start_at);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            if (idx == row + 1) acc5_cyc = cyc;
            idx++;
         end
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      check("feed_budget", int'(guard < 500), 1);
   endtask

   task automatic finish_frame;
      int w = 0;
      while (!bus.done && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("done_timeout", int'(w < 100), 1);
      check("done_after_last", cyc - last_cyc, 1);
      check("win_count", win_count, total);
      check("in_ready_in_done", int'(bus.in_ready), 0);
      repeat (3) @(negedge clk);
      check("done_held", int'(bus.done), 1);
      check("no_extra_windows", win_count, total);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int wc;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.pix_in   = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_win_valid", int'(bus.win_valid), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_pixel", int'(bus.pixel), 0);
      check("rst_data4", int'(bus.data_out_4), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Samples offered while idle are refused.
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_in_ready", int'(bus.in_ready), 0);
      check("idle_no_window", win_count, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // Continuous stream with a stray start pulse while running.
      new_frame();
      feed(16'hFFFF, total, 3);
      finish_frame();

      // Restart from done with a 50% stall pattern.
      new_frame();
      feed(16'b0110_1001_1100_0101, total, -1);
      finish_frame();

      // Abort after 7 samples.
      new_frame();
      feed(16'hFFFF, 7, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_win_valid", int'(bus.win_valid), 0);
      check("abort_in_ready", int'(bus.in_ready), 0);
      check("abort_pixel", int'(bus.pixel), 0);
      check("abort_data4", int'(bus.data_out_4), 0);
      check("abort_data5", int'(bus.data_out_5), 0);
      check("abort_done", int'(bus.done), 0);
      wc = win_count;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_quiet", win_count, wc);
      check("abort_ready_idle", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // Clean frame after the abort.
      new_frame();
      feed(16'hFFFF, total, -1);
      finish_frame();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
